// File: rtl/div_unit.sv
// Multicycle signed restoring divider: quotient to lo, remainder to hi (MIPS DIV semantics).
// Responder side of the div/dloadab/divzero handshake with the control unit.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dloadab,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divzero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [WIDTH-1:0]   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               qneg_q, qneg_d, rneg_q, rneg_d;
    logic               done_q, done_d, dz_q, dz_d;

    logic [WIDTH-1:0]   eff_a, eff_b;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   sub;
    logic               ge;

    // Loading and starting in the same cycle divides the live operands.
    assign eff_a   = dloadab ? a : opa_q;
    assign eff_b   = dloadab ? b : opb_q;
    // 33-bit partial remainder so |A| = 2^31 needs no special case.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign ge      = shifted >= {1'b0, dvs_q};
    assign sub     = shifted[WIDTH-1:0] - dvs_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (div && (eff_b != '0)) state_d = CALC;
            CALC: if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        opa_d  = opa_q;
        opb_d  = opb_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        dz_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (dloadab) begin
                    opa_d = a;
                    opb_d = b;
                end
                if (div) begin
                    if (eff_b == '0) begin
                        dz_d = 1'b1;
                    end else begin
                        qneg_d = eff_a[WIDTH-1] ^ eff_b[WIDTH-1];
                        rneg_d = eff_a[WIDTH-1];
                        quo_d  = eff_a[WIDTH-1] ? -eff_a : eff_a;
                        dvs_d  = eff_b[WIDTH-1] ? -eff_b : eff_b;
                        rem_d  = '0;
                        cnt_d  = '0;
                    end
                end
            end
            CALC: begin
                rem_d = ge ? sub : shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ge};
                cnt_d = cnt_q + CNT_W'(1);
            end
            FIX: begin
                lo_d   = qneg_q ? -quo_q : quo_q;
                hi_d   = rneg_q ? -rem_q : rem_q;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign divzero = dz_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule
